packer: RTL and testbench

PACKER -- requirements
Module: packer

---
 rtl/packer_pkg.sv | 19 +
 rtl/packer_shifter.sv | 42 ++++
 rtl/packer.sv | 163 ++++++++++++++++
 tb/tb_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/packer_pkg.sv
// ----------------------------------------------------------------------------
// packer_pkg
// Shared definitions for the packer and its matching extractor:
//   - default quantized-value width and packed memory-word width
//   - FSM state encoding used by the packing job controller
// ----------------------------------------------------------------------------
package packer_pkg;

   localparam int DEF_MAX_BITWIDTH    = 16;
   localparam int DEF_MEMORY_BITWIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } fsm_state_t;

endpackage

// File: rtl/packer_shifter.sv
// ----------------------------------------------------------------------------
// packer_shifter
// Combinational insert of one quantized value into the packing accumulator.
// Only the low bw bits of the value are kept (two's-complement truncation);
// they are placed starting at bit position fill and OR-ed into the
// accumulator, whose bits at and above fill are zero by construction.
//
// Ports:
//   acc     in  2*MEM_W   current accumulator contents
//   value   in  MAX_BW    quantized value to insert
//   bw      in  BW_W      effective bit width (1..MAX_BW)
//   fill    in  FILL_W    number of valid bits already in acc
//   acc_ins out 2*MEM_W   accumulator with the value inserted
// ----------------------------------------------------------------------------
module packer_shifter
   import packer_pkg::*;
#(
   parameter int MAX_BW = DEF_MAX_BITWIDTH,
   parameter int MEM_W  = DEF_MEMORY_BITWIDTH,
   parameter int BW_W   = $clog2(DEF_MAX_BITWIDTH) + 1,
   parameter int FILL_W = $clog2(2 * DEF_MEMORY_BITWIDTH)
)(
   input  logic [2*MEM_W-1:0] acc,
   input  logic [MAX_BW-1:0]  value,
   input  logic [BW_W-1:0]    bw,
   input  logic [FILL_W-1:0]  fill,
   output logic [2*MEM_W-1:0] acc_ins
);

   logic [MAX_BW-1:0]  masked;
   logic [2*MEM_W-1:0] widened;

   always_comb begin
      masked = '0;
      for (int i = 0; i < MAX_BW; i++) begin
         masked[i] = value[i] & (i < int'(bw));
      end
      widened = {{(2*MEM_W-MAX_BW){1'b0}}, masked};
      acc_ins = acc | (widened << fill);
   end

endmodule

// File: rtl/packer.sv
// ----------------------------------------------------------------------------
// packer
// Packs a stream of bw-bit quantized values LSB-first into MEMORY_BITWIDTH
// memory words, with values straddling word boundaries without gaps. A start
// pulse latches bw and the value count and (re)starts a job; the last partial
// word is zero-padded. done rises once every word has been handed off.
//
// Ports:
//   clk               in   sole clock, rising edge
//   rst               in   asynchronous active-high reset
//   start             in   single-cycle job start / abort
//   bitwidth_d        in   bits per value (0 or > max means max)
//   num_of_input_vals in   number of values in the job
//   values_rdy        in   producer has a valid value
//   value             in   quantized value (two's complement)
//   out_rdy           out  packer accepts a value this cycle
//   next_module_rdy   in   sink accepts the word this cycle
//   word_rdy          out  word is valid
//   word              out  packed memory word
//   done              out  job complete
// ----------------------------------------------------------------------------
module packer
   import packer_pkg::*;
#(
   parameter int MAX_BITWIDTH_QUANTIZED_DATA = DEF_MAX_BITWIDTH,
   parameter int MEMORY_BITWIDTH             = DEF_MEMORY_BITWIDTH
)(
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [$clog2(MAX_BITWIDTH_QUANTIZED_DATA):0] bitwidth_d,
   input  logic [31:0]                               num_of_input_vals,
   input  logic                                      values_rdy,
   input  logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0]    value,
   output logic                                      out_rdy,
   input  logic                                      next_module_rdy,
   output logic                                      word_rdy,
   output logic [MEMORY_BITWIDTH-1:0]                word,
   output logic                                      done
);

   localparam int BW_W   = $clog2(MAX_BITWIDTH_QUANTIZED_DATA) + 1;
   localparam int FILL_W = $clog2(2 * MEMORY_BITWIDTH);
   localparam int ACC_W  = 2 * MEMORY_BITWIDTH;

   localparam logic [FILL_W-1:0] FILL_MEM = FILL_W'(MEMORY_BITWIDTH);
   localparam logic [BW_W-1:0]   BW_MAX   = BW_W'(MAX_BITWIDTH_QUANTIZED_DATA);

   fsm_state_t                 state, state_n;
   logic [ACC_W-1:0]           acc, acc_n, acc_ins;
   logic [FILL_W-1:0]          fill, fill_n;
   logic [31:0]                count, count_n;
   logic [31:0]                num_q, num_n;
   logic [BW_W-1:0]            bw_q, bw_n;
   logic                       out_rdy_n, word_rdy_n, done_n;
   logic [MEMORY_BITWIDTH-1:0] word_n;
   logic                       in_xfer, out_xfer, slot_free;

   assign in_xfer   = values_rdy && out_rdy;
   assign out_xfer  = word_rdy && next_module_rdy;
   // The output register can take a new word if empty or draining now.
   assign slot_free = !word_rdy || out_xfer;

   packer_shifter #(
      .MAX_BW (MAX_BITWIDTH_QUANTIZED_DATA),
      .MEM_W  (MEMORY_BITWIDTH),
      .BW_W   (BW_W),
      .FILL_W (FILL_W)
   ) u_shifter (
      .acc     (acc),
      .value   (value),
      .bw      (bw_q),
      .fill    (fill),
      .acc_ins (acc_ins)
   );

   always_comb begin
      state_n    = state;
      acc_n      = acc;
      fill_n     = fill;
      count_n    = count;
      num_n      = num_q;
      bw_n       = bw_q;
      word_n     = word;
      word_rdy_n = word_rdy;

      if (out_xfer) begin
         word_rdy_n = 1'b0;
      end

      if (start) begin
         acc_n      = '0;
         fill_n     = '0;
         count_n    = '0;
         word_rdy_n = 1'b0;
         num_n      = num_of_input_vals;
         bw_n       = (bitwidth_d == '0 || bitwidth_d > BW_MAX) ? BW_MAX : bitwidth_d;
         state_n    = (num_of_input_vals == 32'd0) ? ST_DONE : ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               // out_rdy is only high while fill < word width, so an accept
               // and a full-word emission never coincide.
               if (in_xfer) begin
                  acc_n   = acc_ins;
                  fill_n  = fill + FILL_W'(bw_q);
                  count_n = count + 32'd1;
               end else if (fill >= FILL_MEM && slot_free) begin
                  word_n     = acc[MEMORY_BITWIDTH-1:0];
                  acc_n      = acc >> MEMORY_BITWIDTH;
                  fill_n     = fill - FILL_MEM;
                  word_rdy_n = 1'b1;
               end
               if (count == num_q) begin
                  state_n = ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               // Bits above fill are zero, so a partial word is padded for free.
               if (fill != '0 && slot_free) begin
                  word_n     = acc[MEMORY_BITWIDTH-1:0];
                  acc_n      = acc >> MEMORY_BITWIDTH;
                  fill_n     = (fill >= FILL_MEM) ? (fill - FILL_MEM) : '0;
                  word_rdy_n = 1'b1;
               end else if (fill == '0 && !word_rdy) begin
                  state_n = ST_DONE;
               end
            end
            default: ;
         endcase
      end

      out_rdy_n = (state_n == ST_RUN) && (fill_n < FILL_MEM) && (count_n < num_n);
      done_n    = (state_n == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         acc      <= '0;
         fill     <= '0;
         count    <= '0;
         num_q    <= '0;
         bw_q     <= '0;
         out_rdy  <= 1'b0;
         word_rdy <= 1'b0;
         word     <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         fill     <= fill_n;
         count    <= count_n;
         num_q    <= num_n;
         bw_q     <= bw_n;
         out_rdy  <= out_rdy_n;
         word_rdy <= word_rdy_n;
         word     <= word_n;
         done     <= done_n;
      end
   end

endmodule

// File: tb/tb_packer.sv
// ----------------------------------------------------------------------------
// tb_packer
// Directed self-checking bench for packer (16-bit values, 16-bit words).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A monitor collects every transferred word into got[$].
// ----------------------------------------------------------------------------
module tb_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  bitwidth_d = '0;
   logic [31:0] num_of_input_vals = '0;
   logic        values_rdy = 1'b0;
   logic [15:0] value = '0;
   logic        out_rdy;
   logic        next_module_rdy = 1'b1;
   logic        word_rdy;
   logic [15:0] word;
   logic        done;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] vals[$];
   logic [15:0] got[$];

   packer #(
      .MAX_BITWIDTH_QUANTIZED_DATA (16),
      .MEMORY_BITWIDTH             (16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .bitwidth_d        (bitwidth_d),
      .num_of_input_vals (num_of_input_vals),
      .values_rdy        (values_rdy),
      .value             (value),
      .out_rdy           (out_rdy),
      .next_module_rdy   (next_module_rdy),
      .word_rdy          (word_rdy),
      .word              (word),
      .done              (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (word_rdy === 1'b1 && next_module_rdy) got.push_back(word);
   end

   function automatic logic [15:0] got_at(input int i);
      if (i < got.size()) return got[i];
      return 16'hxxxx;
   endfunction

   task automatic pulse_start(input int bw, input int num);
      @(posedge clk); #1;
      start             = 1'b1;
      bitwidth_d        = 5'(bw);
      num_of_input_vals = 32'(num);
      got.delete();
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Runs a whole job from vals[], optionally stalling the sink for `stall`
   // cycles on the first word and checking it is held meanwhile.
   task automatic run_job(input int bw, input int num, input int stall);
      int idx = 0;
      int stall_cnt = 0;
      bit finished = 0;
      next_module_rdy = (stall == 0);
      pulse_start(bw, num);
      values_rdy = (num > 0);
      if (num > 0) value = vals[0];
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         @(negedge clk);
         if (stall > 0 && stall_cnt < stall && (stall_cnt > 0 || word_rdy === 1'b1)) begin
            n_cmp++;
            if (word_rdy !== 1'b1 || word !== vals[0]) begin
               n_fail++;
               $display("FAIL hold_word[%0d]: word_rdy=%b word=%h required word_rdy=1 word=%h",
                        stall_cnt, word_rdy, word, vals[0]);
            end
            if (stall_cnt >= 1) begin
               n_cmp++;
               if (out_rdy !== 1'b0) begin
                  n_fail++;
                  $display("FAIL hold_out_rdy[%0d]: got %b required 0", stall_cnt, out_rdy);
               end
            end
            stall_cnt++;
         end
         if (values_rdy && out_rdy === 1'b1) idx++;
         if (done === 1'b1) begin
            finished = 1;
         end else begin
            @(posedge clk); #1;
            values_rdy = (idx < num);
            if (idx < num) value = vals[idx];
            else value = 16'h0000;
            next_module_rdy = (stall == 0) || (stall_cnt >= stall);
         end
      end
      values_rdy      = 1'b0;
      next_module_rdy = 1'b1;
      n_cmp++;
      if (!finished) begin
         n_fail++;
         $display("FAIL job_timeout: done=%b after 3000 cycles, required 1", done);
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (out_rdy !== 1'b0)   begin n_fail++; $display("FAIL rst_out_rdy: got %b required 0", out_rdy); end
      n_cmp++; if (word_rdy !== 1'b0)  begin n_fail++; $display("FAIL rst_word_rdy: got %b required 0", word_rdy); end
      n_cmp++; if (word !== 16'h0000)  begin n_fail++; $display("FAIL rst_word: got %h required 0000", word); end
      n_cmp++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
      @(posedge clk); #1;
      rst        = 1'b0;
      values_rdy = 1'b1;
      value      = 16'h5555;
      got.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_rdy !== 1'b0 || word_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore[%0d]: out_rdy=%b word_rdy=%b required 0 0", i, out_rdy, word_rdy);
         end
      end
      values_rdy = 1'b0;
   endtask

   task automatic test_bw4();
      vals = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      run_job(4, 4, 0);
      n_cmp++; if (got.size() != 1)       begin n_fail++; $display("FAIL bw4_count: got %0d required 1", got.size()); end
      n_cmp++; if (got_at(0) !== 16'h4321) begin n_fail++; $display("FAIL bw4_word: got %h required 4321", got_at(0)); end
      n_cmp++; if (done !== 1'b1)         begin n_fail++; $display("FAIL bw4_done: got %b required 1", done); end
      n_cmp++; if (out_rdy !== 1'b0)      begin n_fail++; $display("FAIL bw4_done_out_rdy: got %b required 0", out_rdy); end
   endtask

   task automatic test_bw5_flush();
      vals = '{16'h001F, 16'h0000, 16'h001F, 16'h0001};
      run_job(5, 4, 0);
      n_cmp++; if (got.size() != 2)        begin n_fail++; $display("FAIL bw5_count: got %0d required 2", got.size()); end
      n_cmp++; if (got_at(0) !== 16'hFC1F) begin n_fail++; $display("FAIL bw5_word0: got %h required FC1F", got_at(0)); end
      n_cmp++; if (got_at(1) !== 16'h0000) begin n_fail++; $display("FAIL bw5_word1: got %h required 0000", got_at(1)); end
      n_cmp++; if (done !== 1'b1)          begin n_fail++; $display("FAIL bw5_done: got %b required 1", done); end
   endtask

   task automatic test_bw3_truncate();
      vals = '{16'hFFFF};
      run_job(3, 1, 0);
      n_cmp++; if (got.size() != 1)        begin n_fail++; $display("FAIL bw3_count: got %0d required 1", got.size()); end
      n_cmp++; if (got_at(0) !== 16'h0007) begin n_fail++; $display("FAIL bw3_word: got %h required 0007", got_at(0)); end
   endtask

   task automatic test_bw_clamp();
      vals = '{16'h1234, 16'hABCD};
      run_job(0, 2, 0);
      n_cmp++; if (got.size() != 2)        begin n_fail++; $display("FAIL clamp0_count: got %0d required 2", got.size()); end
      n_cmp++; if (got_at(1) !== 16'hABCD) begin n_fail++; $display("FAIL clamp0_word1: got %h required ABCD", got_at(1)); end
      run_job(17, 2, 0);
      n_cmp++; if (got.size() != 2)        begin n_fail++; $display("FAIL clamp17_count: got %0d required 2", got.size()); end
      n_cmp++; if (got_at(0) !== 16'h1234) begin n_fail++; $display("FAIL clamp17_word0: got %h required 1234", got_at(0)); end
   endtask

   task automatic test_backpressure();
      vals = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      run_job(16, 3, 5);
      n_cmp++; if (got.size() != 3)        begin n_fail++; $display("FAIL bp_count: got %0d required 3", got.size()); end
      n_cmp++; if (got_at(0) !== 16'hAAAA) begin n_fail++; $display("FAIL bp_word0: got %h required AAAA", got_at(0)); end
      n_cmp++; if (got_at(1) !== 16'hBBBB) begin n_fail++; $display("FAIL bp_word1: got %h required BBBB", got_at(1)); end
      n_cmp++; if (got_at(2) !== 16'hCCCC) begin n_fail++; $display("FAIL bp_word2: got %h required CCCC", got_at(2)); end
   endtask

   task automatic test_num0();
      pulse_start(5, 0);
      n_cmp++; if (done !== 1'b1)     begin n_fail++; $display("FAIL num0_done: got %b required 1", done); end
      n_cmp++; if (out_rdy !== 1'b0)  begin n_fail++; $display("FAIL num0_out_rdy: got %b required 0", out_rdy); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (word_rdy !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL num0_hold[%0d]: word_rdy=%b done=%b required 0 1", i, word_rdy, done);
         end
      end
      n_cmp++; if (got.size() != 0) begin n_fail++; $display("FAIL num0_words: got %0d required 0", got.size()); end
   endtask

   task automatic test_rst_midjob_bw7();
      logic [16*44-1:0] stream;
      logic [6:0]       field;
      logic [15:0]      exp_v, act_v;
      vals.delete();
      for (int i = 0; i < 100; i++) vals.push_back(16'($urandom));
      pulse_start(7, 100);
      values_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         value = vals[i];
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (out_rdy !== 1'b0 || word_rdy !== 1'b0 || word !== 16'h0000 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL midjob_rst: out_rdy=%b word_rdy=%b word=%h done=%b required 0 0 0000 0",
                  out_rdy, word_rdy, word, done);
      end
      values_rdy = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_job(7, 100, 0);
      n_cmp++;
      if (got.size() != 44) begin
         n_fail++;
         $display("FAIL bw7_count: got %0d required 44", got.size());
      end
      stream = '0;
      for (int w = 0; w < 44; w++) stream[w*16 +: 16] = got_at(w);
      for (int i = 0; i < 100; i++) begin
         field = stream[i*7 +: 7];
         act_v = {{9{field[6]}}, field};
         exp_v = {{9{vals[i][6]}}, vals[i][6:0]};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL bw7_value[%0d]: got %h required %h", i, act_v, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bw4();
      test_bw5_flush();
      test_bw3_truncate();
      test_bw_clamp();
      test_backpressure();
      test_num0();
      test_rst_midjob_bw7();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
